// File: rtl/ppu_tile_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ppu_pkg
// Brief    : Shared types and constants for the background tile engine.
// Revision : 1.0
// ============================================================================
package ppu_pkg;

   localparam int ROW_W         = 320;
   localparam int ROWS          = 240;
   localparam int MAP_TILES     = 64;
   localparam int TILES_PER_ROW = 41;

   typedef struct packed {
      logic [5:0] palette_id;
      logic [9:0] pattern;
   } tile_entry_t;

   typedef struct packed {
      logic [5:0] palette_id;
      logic [3:0] color_idx;
   } rowram_px_t;

endpackage
`default_nettype wire

// File: rtl/ppu_tile_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : ppu_tile_engine_if
// Brief    : Row control, VRAM read ports and row RAM write port of the engine.
// Revision : 1.0
// ============================================================================
interface ppu_tile_engine_if;

   logic        row_start;
   logic [7:0]  row_num;
   logic [8:0]  scroll_x;
   logic [8:0]  scroll_y;
   logic        enable;
   logic [10:0] tilram_addr;
   logic [63:0] tilram_rddata;
   logic [11:0] patram_addr;
   logic [63:0] patram_rddata;
   logic [8:0]  rowram_wraddr;
   logic [9:0]  rowram_wrdata;
   logic        rowram_wren;
   logic        busy;
   logic        done;

   modport master (
      input  row_start, row_num, scroll_x, scroll_y, enable,
      input  tilram_rddata, patram_rddata,
      output tilram_addr, patram_addr,
      output rowram_wraddr, rowram_wrdata, rowram_wren, busy, done
   );

   modport slave (
      output row_start, row_num, scroll_x, scroll_y, enable,
      output tilram_rddata, patram_rddata,
      input  tilram_addr, patram_addr,
      input  rowram_wraddr, rowram_wrdata, rowram_wren, busy, done
   );

endinterface
`default_nettype wire

// File: rtl/ppu_tile_engine_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : ppu_tile_addr_gen
// Brief    : Map index, VRAM addresses and tile entry select for tile t.
// Revision : 1.0
// ============================================================================
module ppu_tile_addr_gen
   import ppu_pkg::*;
#(
   parameter bit LAYER = 1'b0
) (
   input  wire logic [7:0]  row_num,
   input  wire logic [8:0]  scroll_x,
   input  wire logic [8:0]  scroll_y,
   input  wire logic [5:0]  tile_t,
   input  wire logic [9:0]  pattern,
   input  wire logic [63:0] tilram_rddata,
   output tile_entry_t      entry,
   output logic [10:0]      tilram_addr,
   output logic [11:0]      patram_addr,
   output logic             fine_y0
);

   logic [8:0]  w_map_y;
   logic [5:0]  w_tile_col;
   logic [11:0] w_map_idx;

   // Both sums wrap naturally at the vector width (512-pixel map, 64-tile row).
   assign w_map_y     = {1'b0, row_num} + scroll_y;
   assign w_tile_col  = scroll_x[8:3] + tile_t;
   assign w_map_idx   = {w_map_y[8:3], w_tile_col};

   assign tilram_addr = {LAYER, w_map_idx[11:2]};
   assign entry       = tile_entry_t'(tilram_rddata[{w_map_idx[1:0], 4'b0000} +: 16]);
   assign patram_addr = {pattern, w_map_y[2:1]};
   assign fine_y0     = w_map_y[0];

endmodule
`default_nettype wire

// File: rtl/ppu_tile_engine.sv
`default_nettype none
// ============================================================================
// Module   : ppu_tile_engine
// Brief    : Renders one 320-pixel scanline of a tile layer into row RAM.
// Revision : 1.0
// ============================================================================
module ppu_tile_engine #(
   parameter bit LAYER  = 1'b0,
   parameter int RD_LAT = 2,
   parameter int ROW_W  = 320
) (
   input  wire logic          clk,
   input  wire logic          rst,
   ppu_tile_engine_if.master  bus
);

   import ppu_pkg::*;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_TILE_RD = 3'd1;
   localparam logic [2:0] S_PAT_RD  = 3'd2;
   localparam logic [2:0] S_PIX     = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [1:0] C_LAT       = 2'(RD_LAT);
   localparam logic [5:0] C_LAST_TILE = 6'(TILES_PER_ROW - 1);
   localparam logic [8:0] C_ROW_W     = 9'(ROW_W);

   logic [2:0]  r_state;
   logic [7:0]  r_row_num;
   logic [8:0]  r_scroll_x;
   logic [8:0]  r_scroll_y;
   logic        r_enable;
   logic [5:0]  r_t;
   logic [1:0]  r_wait;
   logic [2:0]  r_pix;
   tile_entry_t r_entry;
   logic [31:0] r_pat_row;

   tile_entry_t w_entry;
   logic [10:0] w_tilram_addr;
   logic [11:0] w_patram_addr;
   logic        w_fine_y0;
   logic [9:0]  w_x;
   logic        w_wren;
   logic        w_busy;
   rowram_px_t  w_px;

   ppu_tile_addr_gen #(
      .LAYER (LAYER)
   ) u_addr_gen (
      .row_num       (r_row_num),
      .scroll_x      (r_scroll_x),
      .scroll_y      (r_scroll_y),
      .tile_t        (r_t),
      .pattern       (r_entry.pattern),
      .tilram_rddata (bus.tilram_rddata),
      .entry         (w_entry),
      .tilram_addr   (w_tilram_addr),
      .patram_addr   (w_patram_addr),
      .fine_y0       (w_fine_y0)
   );

   // row_start takes priority in every state, which covers both abort and DONE overlap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_row_num  <= '0;
         r_scroll_x <= '0;
         r_scroll_y <= '0;
         r_enable   <= 1'b0;
         r_t        <= '0;
         r_wait     <= '0;
         r_pix      <= '0;
         r_entry    <= '0;
         r_pat_row  <= '0;
      end else if (bus.row_start) begin
         r_state    <= S_TILE_RD;
         r_row_num  <= bus.row_num;
         r_scroll_x <= bus.scroll_x;
         r_scroll_y <= bus.scroll_y;
         r_enable   <= bus.enable;
         r_t        <= '0;
         r_wait     <= '0;
         r_pix      <= '0;
      end else begin
         case (r_state)
            S_TILE_RD: begin
               if (r_wait == C_LAT) begin
                  r_entry <= w_entry;
                  r_wait  <= '0;
                  r_state <= S_PAT_RD;
               end else begin
                  r_wait <= r_wait + 2'd1;
               end
            end
            S_PAT_RD: begin
               if (r_wait == C_LAT) begin
                  r_pat_row <= bus.patram_rddata[{w_fine_y0, 5'b00000} +: 32];
                  r_wait    <= '0;
                  r_pix     <= '0;
                  r_state   <= S_PIX;
               end else begin
                  r_wait <= r_wait + 2'd1;
               end
            end
            S_PIX: begin
               r_pix <= r_pix + 3'd1;
               if (r_pix == 3'd7) begin
                  if (r_t == C_LAST_TILE) begin
                     r_state <= S_DONE;
                  end else begin
                     r_t     <= r_t + 6'd1;
                     r_state <= S_TILE_RD;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Screen x = 8t + p - fine scroll; negative or >= ROW_W pixels are dropped.
   assign w_x    = {1'b0, r_t, r_pix} - {7'd0, r_scroll_x[2:0]};
   assign w_wren = (r_state == S_PIX) && !w_x[9] && (w_x[8:0] < C_ROW_W);
   assign w_busy = (r_state != S_IDLE);

   always_comb begin
      w_px = '0;
      if (r_enable) begin
         w_px.palette_id = r_entry.palette_id;
         w_px.color_idx  = r_pat_row[{r_pix, 2'b00} +: 4];
      end
   end

   assign bus.rowram_wren   = w_wren;
   assign bus.rowram_wraddr = w_wren ? w_x[8:0] : 9'd0;
   assign bus.rowram_wrdata = w_wren ? w_px : 10'd0;
   assign bus.busy          = w_busy;
   assign bus.done          = (r_state == S_DONE);
   assign bus.tilram_addr   = w_busy ? w_tilram_addr : 11'd0;
   assign bus.patram_addr   = w_busy ? w_patram_addr : 12'd0;

endmodule
`default_nettype wire

// File: tb/tb_ppu_tile_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppu_tile_engine
// Brief    : Scoreboard bench for ppu_tile_engine with a pipelined VRAM model.
// Revision : 1.0
// ============================================================================
module tb_ppu_tile_engine;

   localparam int RD_LAT  = 2;
   localparam int BUSY_CY = 41 * (2 * (RD_LAT + 1) + 8) + 1;

   logic clk;
   logic rst;
   ppu_tile_engine_if bus ();

   ppu_tile_engine #(.LAYER(1'b0), .RD_LAT(RD_LAT), .ROW_W(320)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [63:0] tmem [2048];
   logic [63:0] pmem [4096];
   logic [63:0] tpipe [3];
   logic [63:0] ppipe [3];

   always @(posedge clk) begin
      tpipe[0] <= tmem[bus.tilram_addr];
      tpipe[1] <= tpipe[0];
      tpipe[2] <= tpipe[1];
      ppipe[0] <= pmem[bus.patram_addr];
      ppipe[1] <= ppipe[0];
      ppipe[2] <= ppipe[1];
   end
   assign bus.tilram_rddata = tpipe[RD_LAT-1];
   assign bus.patram_rddata = ppipe[RD_LAT-1];

   int checks = 0;
   int errors = 0;
   int wr_count, busy_count, done_count;
   int first_addr, last_addr;
   bit mono_bad, saw80;
   logic [9:0] first8 [8];
   logic [18:0] exp_q [$];

   // Monitor: every write is popped against the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.busy) busy_count++;
         if (bus.done) done_count++;
         if (bus.rowram_wren) begin
            if (wr_count == 0) first_addr = int'(bus.rowram_wraddr);
            else if (int'(bus.rowram_wraddr) <= last_addr) mono_bad = 1'b1;
            if (bus.rowram_wraddr == 9'd80) saw80 = 1'b1;
            if (bus.rowram_wraddr < 9'd8) first8[bus.rowram_wraddr[2:0]] = bus.rowram_wrdata;
            last_addr = int'(bus.rowram_wraddr);
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL write_unexpected addr=%0d data=%h", bus.rowram_wraddr, bus.rowram_wrdata);
            end else begin
               logic [18:0] e;
               e = exp_q.pop_front();
               if ({bus.rowram_wraddr, bus.rowram_wrdata} !== e) begin
                  errors++;
                  $display("FAIL write_data got addr=%0d data=%h exp addr=%0d data=%h",
                           bus.rowram_wraddr, bus.rowram_wrdata, e[18:10], e[9:0]);
               end
            end
         end
      end
   end

   // Screen-first model: for each x, find the map pixel it shows.
   task automatic push_row(input logic [7:0] rn, input logic [8:0] sx, input logic [8:0] sy, input bit en);
      for (int x = 0; x < 320; x++) begin
         logic [8:0]  ax, my;
         logic [11:0] mi;
         logic [63:0] tw, pw;
         logic [15:0] ent;
         logic [3:0]  pix;
         logic [9:0]  d;
         ax  = 9'(x) + sx;
         my  = {1'b0, rn} + sy;
         mi  = {my[8:3], ax[8:3]};
         tw  = tmem[{1'b0, mi[11:2]}];
         ent = tw[16*mi[1:0] +: 16];
         pw  = pmem[{ent[9:0], my[2:1]}];
         pix = pw[32*my[0] + 4*ax[2:0] +: 4];
         d   = en ? {ent[15:10], pix} : 10'd0;
         exp_q.push_back({9'(x), d});
      end
   endtask

   task automatic start_row(input logic [7:0] rn, input logic [8:0] sx, input logic [8:0] sy, input bit en);
      @(posedge clk); #1;
      bus.row_num = rn; bus.scroll_x = sx; bus.scroll_y = sy; bus.enable = en;
      bus.row_start = 1'b1;
      @(posedge clk); #1;
      bus.row_start = 1'b0;
      bus.scroll_x = 9'h1ff; bus.scroll_y = 9'h1ff; bus.enable = ~en;
      exp_q.delete();
      wr_count = 0; busy_count = 0; mono_bad = 1'b0; saw80 = 1'b0;
      first_addr = -1; last_addr = -1;
      push_row(rn, sx, sy, en);
   endtask

   task automatic wait_done(input int d0);
      int i;
      for (i = 0; i < 3000 && done_count == d0; i++) @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (done_count == d0) begin
         errors++;
         $display("FAIL done_timeout got no done within %0d cycles", i);
      end
   endtask

   task automatic check_row_end(input string nm);
      checks++;
      if (wr_count !== 320) begin errors++; $display("FAIL %s_wr_count got %0d exp 320", nm, wr_count); end
      checks++;
      if (exp_q.size() !== 0) begin errors++; $display("FAIL %s_missing got %0d left exp 0", nm, exp_q.size()); end
      checks++;
      if (mono_bad) begin errors++; $display("FAIL %s_monotonic got non-increasing addr exp increasing", nm); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.rowram_wren, bus.rowram_wraddr, bus.rowram_wrdata,
           bus.tilram_addr, bus.patram_addr} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%b done=%b wren=%b til=%h pat=%h exp all 0",
                  bus.busy, bus.done, bus.rowram_wren, bus.tilram_addr, bus.patram_addr);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      done_count = 0;
      start_row(8'd0, 9'd0, 9'd0, 1'b1);
      wait_done(0);
      check_row_end("basic");
      checks++;
      if (done_count !== 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", done_count); end
      checks++;
      if (busy_count !== BUSY_CY) begin errors++; $display("FAIL basic_busy got %0d exp %0d", busy_count, BUSY_CY); end
      for (int i = 0; i < 8; i++) begin
         logic [9:0] e;
         e = {6'd5, i[3:0]};
         checks++;
         if (first8[i] !== e) begin errors++; $display("FAIL basic_px%0d got %h exp %h", i, first8[i], e); end
      end
   endtask

   task automatic test_scroll_x();
      done_count = 0;
      start_row(8'd0, 9'd3, 9'd0, 1'b1);
      wait_done(0);
      check_row_end("scroll_x");
      checks++;
      if (first_addr !== 0) begin errors++; $display("FAIL scroll_x_first got %0d exp 0", first_addr); end
      checks++;
      if (last_addr !== 319) begin errors++; $display("FAIL scroll_x_last got %0d exp 319", last_addr); end
   endtask

   task automatic test_wrap();
      logic [11:0] ep;
      done_count = 0;
      ep = {tmem[0][9:0], 2'b01};
      start_row(8'd5, 9'd0, 9'd510, 1'b1);
      checks++;
      if (bus.tilram_addr !== 11'd0) begin errors++; $display("FAIL wrap_tilram got %h exp 000", bus.tilram_addr); end
      repeat (RD_LAT + 1) @(posedge clk);
      #1;
      checks++;
      if (bus.patram_addr !== ep) begin errors++; $display("FAIL wrap_patram got %h exp %h", bus.patram_addr, ep); end
      wait_done(0);
      check_row_end("wrap");
   endtask

   task automatic test_disable();
      done_count = 0;
      start_row(8'd17, 9'd5, 9'd40, 1'b0);
      wait_done(0);
      check_row_end("disable");
      checks++;
      if (busy_count !== BUSY_CY) begin errors++; $display("FAIL disable_busy got %0d exp %0d", busy_count, BUSY_CY); end
   endtask

   task automatic test_restart();
      int i;
      done_count = 0;
      start_row(8'd9, 9'd0, 9'd0, 1'b1);
      for (i = 0; i < 2000 && !saw80; i++) @(posedge clk);
      checks++;
      if (!saw80) begin errors++; $display("FAIL restart_reach_t10 got no x=80 exp x=80"); end
      start_row(8'd100, 9'd0, 9'd7, 1'b1);
      wait_done(0);
      check_row_end("restart");
      checks++;
      if (first_addr !== 0) begin errors++; $display("FAIL restart_first got %0d exp 0", first_addr); end
      checks++;
      if (done_count !== 1) begin errors++; $display("FAIL restart_done_count got %0d exp 1", done_count); end
   endtask

   task automatic test_rst_mid();
      int i;
      start_row(8'd3, 9'd0, 9'd0, 1'b1);
      for (i = 0; i < 200 && wr_count < 3; i++) @(negedge clk);
      @(posedge clk); #2;
      checks++;
      if (bus.rowram_wren !== 1'b1) begin errors++; $display("FAIL rst_pre_wren got %b exp 1", bus.rowram_wren); end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.rowram_wren, bus.rowram_wraddr, bus.rowram_wrdata,
           bus.tilram_addr, bus.patram_addr} !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs got busy=%b wren=%b addr=%0d til=%h pat=%h exp all 0",
                  bus.busy, bus.rowram_wren, bus.rowram_wraddr, bus.tilram_addr, bus.patram_addr);
      end
      exp_q.delete();
      done_count = 0; wr_count = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      checks++;
      if (done_count !== 0 || wr_count !== 0) begin
         errors++;
         $display("FAIL rst_mid_quiet got done=%0d writes=%0d exp 0 0", done_count, wr_count);
      end
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) tmem[i] = {$urandom, $urandom};
      for (int i = 0; i < 4096; i++) pmem[i] = {$urandom, $urandom};
      tmem[0][15:0]  = 16'h1401;
      pmem[4][31:0]  = 32'h76543210;
      bus.row_start = 1'b0; bus.row_num = '0; bus.scroll_x = '0; bus.scroll_y = '0; bus.enable = 1'b0;
      wr_count = 0; busy_count = 0; done_count = 0; mono_bad = 1'b0; saw80 = 1'b0;
      first_addr = -1; last_addr = -1;
      test_reset();
      test_basic();
      test_scroll_x();
      test_wrap();
      test_disable();
      test_restart();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
